// File: rtl/coeff_mod_sequencer_if.sv
// Signal bundle between the coefficient sequencer, its source/result buffers and the
// iterative modular reducer. The sequencer takes the master view.
interface coeff_mod_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] p;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  mod_start;
  logic [DATA_WIDTH-1:0] mod_m;
  logic [DATA_WIDTH-1:0] mod_p;
  logic [DATA_WIDTH-1:0] mod_m_mod_p;
  logic                  mod_done;

  modport master (
    input  start, count, p, rd_data, mod_m_mod_p, mod_done,
    output busy, done, error, rd_en, rd_addr, wr_en, wr_addr, wr_data,
           mod_start, mod_m, mod_p
  );

  modport slave (
    output start, count, p, rd_data, mod_m_mod_p, mod_done,
    input  busy, done, error, rd_en, rd_addr, wr_en, wr_addr, wr_data,
           mod_start, mod_m, mod_p
  );
endinterface

// File: rtl/coeff_mod_sequencer.sv
// Walks a buffer of signed coefficients, reduces each one mod p through the external
// reducer's start/done handshake and writes the residues to a result buffer.
module coeff_mod_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WAIT   = 1024
) (
  input logic                   clk,
  input logic                   rst,
  coeff_mod_sequencer_if.master bus
);
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, ISSUE, WAIT_DONE, WRITE, FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] p_q, p_d;
  logic [DATA_WIDTH-1:0] mod_m_q, mod_m_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  error_q, error_d;
  logic                  short_q, short_d;
  logic                  last_idx;

  assign last_idx = ({1'b0, idx_q} == count_q - 1'b1);

  always_comb begin
    // NOTE: every next-state value and output gets a default first, so no path infers a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    count_d       = count_q;
    p_d           = p_q;
    mod_m_d       = mod_m_q;
    res_d         = res_q;
    wait_d        = wait_q;
    error_d       = error_q;
    short_d       = short_q;
    bus.rd_en     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.mod_start = 1'b0;
    bus.done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          count_d = bus.count;
          p_d     = bus.p;
          idx_d   = '0;
          error_d = 1'b0;
          // A zero modulus would hang the reducer, so it never gets issued.
          if (bus.p == '0) begin
            error_d = 1'b1;
            short_d = 1'b1;
            state_d = FINISH;
          end else if (bus.count == '0) begin
            short_d = 1'b1;
            state_d = FINISH;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        bus.rd_en = 1'b1;
        state_d   = LOAD;
      end
      LOAD: begin
        mod_m_d = bus.rd_data;
        state_d = ISSUE;
      end
      ISSUE: begin
        bus.mod_start = 1'b1;
        wait_d        = '0;
        state_d       = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.mod_done) begin
          res_d   = bus.mod_m_mod_p;
          state_d = WRITE;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WRITE: begin
        bus.wr_en = 1'b1;
        if (last_idx) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end
      end
      FINISH: begin
        // Runs rejected in IDLE spend one extra cycle here so done lands two cycles after start.
        if (short_q) begin
          short_d = 1'b0;
        end else begin
          bus.done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset as well, because mod_m, mod_p and wr_data must read 0 after reset.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      p_q     <= '0;
      mod_m_q <= '0;
      res_q   <= '0;
      wait_q  <= '0;
      error_q <= 1'b0;
      short_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      p_q     <= p_d;
      mod_m_q <= mod_m_d;
      res_q   <= res_d;
      wait_q  <= wait_d;
      error_q <= error_d;
      short_q <= short_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.error   = error_q;
  assign bus.rd_addr = idx_q;
  assign bus.wr_addr = idx_q;
  assign bus.wr_data = res_q;
  assign bus.mod_m   = mod_m_q;
  assign bus.mod_p   = p_q;
endmodule

// File: tb/tb_coeff_mod_sequencer.sv
// Directed bench for coeff_mod_sequencer: table of whole-polynomial runs plus hand-written
// sequences for reset values, start-while-busy and reset in the middle of a run.
module tb_coeff_mod_sequencer;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int MW  = 16;
  localparam int LAT = 3;
  localparam int NV  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coeff_mod_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  coeff_mod_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Source buffer: read data valid one cycle after rd_en.
  logic [DW-1:0] src_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= src_mem[bus.rd_addr];
  end

  // Monitors: cumulative activity counts and write log, sampled on the falling edge.
  int            tot_start = 0;
  int            tot_rd    = 0;
  int            tot_done  = 0;
  logic [AW-1:0] wa_q [$];
  logic [DW-1:0] wd_q [$];
  always @(negedge clk) begin
    if (bus.mod_start) tot_start++;
    if (bus.rd_en)     tot_rd++;
    if (bus.done)      tot_done++;
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
    end
  end

  // Reducer stub: answers LAT cycles after mod_start with m mod p in [0, p),
  // unless the request number in this run exceeds hang_at.
  int   base_start = 0;
  int   hang_at    = 99;
  int   red_cnt;
  logic red_pend;

  function automatic logic [DW-1:0] ref_mod(input logic [DW-1:0] m, input logic [DW-1:0] pp);
    longint sm, up, r;
    if (pp == '0) return '0;
    sm = longint'($signed(m));
    up = longint'({32'b0, pp});
    r  = sm % up;
    if (r < 0) r = r + up;
    return r[DW-1:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      red_pend <= 1'b0;
      red_cnt  <= 0;
    end else if (bus.mod_start) begin
      red_pend <= 1'b1;
      red_cnt  <= 1;
    end else if (bus.mod_done) begin
      red_pend <= 1'b0;
    end else if (red_pend) begin
      red_cnt <= red_cnt + 1;
    end
  end
  assign bus.mod_done    = red_pend && (red_cnt == LAT) && ((tot_start - base_start) <= hang_at);
  assign bus.mod_m_mod_p = ref_mod(bus.mod_m, bus.mod_p);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0]        p;
    int                   count;
    logic [4:0][DW-1:0]   coeff;
    logic [4:0][DW-1:0]   res;
    int                   offset;   // cycles from the start cycle to the done cycle
    logic                 err;
    int                   n_wr;
    int                   n_start;
    int                   hang;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t make_vec(input int p, input int count, input int offset, input logic err,
                                    input int n_wr, input int n_start, input int hang);
    vec_t v;
    v.p = DW'(p); v.count = count; v.offset = offset; v.err = err;
    v.n_wr = n_wr; v.n_start = n_start; v.hang = hang;
    v.coeff = '0; v.res = '0;
    return v;
  endfunction

  task automatic put(input int vi, input int ci, input int c, input int r);
    vecs[vi].coeff[ci] = DW'(c);
    vecs[vi].res[ci]   = DW'(r);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int b_rd, b_done, b_wr, k;
    for (int i = 0; i < 5; i++) src_mem[i] = v.coeff[i];
    hang_at = v.hang;
    @(negedge clk);
    base_start = tot_start;
    b_rd       = tot_rd;
    b_done     = tot_done;
    b_wr       = wa_q.size();
    bus.start  = 1'b1;
    bus.p      = v.p;
    bus.count  = (AW+1)'(v.count);
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 1) begin
        check({tag, " busy after start"}, bus.busy, 1'b1);
        check({tag, " error after start"}, bus.error, (v.p == '0));
      end
      if (bus.done) break;
    end
    check({tag, " done cycle"}, k, v.offset);
    check({tag, " error at done"}, bus.error, v.err);
    @(negedge clk);
    check({tag, " busy after done"}, bus.busy, 1'b0);
    check({tag, " done single cycle"}, bus.done, 1'b0);
    repeat (3) @(negedge clk);
    check({tag, " error sticky"}, bus.error, v.err);
    check({tag, " done pulses"}, tot_done - b_done, 1);
    check({tag, " mod_start pulses"}, tot_start - base_start, v.n_start);
    check({tag, " rd_en cycles"}, tot_rd - b_rd, v.n_start);
    check({tag, " writes"}, wa_q.size() - b_wr, v.n_wr);
    for (int i = 0; i < v.n_wr && (b_wr + i) < wa_q.size(); i++) begin
      check($sformatf("%s wr_addr[%0d]", tag, i), wa_q[b_wr+i], i);
      check($sformatf("%s wr_data[%0d]", tag, i), wd_q[b_wr+i], v.res[i]);
    end
  endtask

  initial begin
    int b_wr, b_done, k, n;

    // Cost per coefficient is LAT+4 = 7 cycles; done at start + 7*count + 1.
    vecs[0] = make_vec(7, 4, 29, 1'b0, 4, 4, 99);
    put(0, 0, 20, 6); put(0, 1, -20, 1); put(0, 2, 6, 6); put(0, 3, 0, 0);
    vecs[1] = make_vec(5, 1, 8, 1'b0, 1, 1, 99);
    put(1, 0, -5, 0);
    vecs[2] = make_vec(3, 0, 2, 1'b0, 0, 0, 99);
    vecs[3] = make_vec(0, 8, 2, 1'b1, 0, 0, 99);
    vecs[4] = make_vec(13, 3, 22, 1'b0, 3, 3, 99);
    put(4, 0, -1, 12); put(4, 1, 100, 9); put(4, 2, 13, 0);
    // Second coefficient never completes: timeout 16 cycles after WAIT_DONE entry (cycle 11).
    vecs[5] = make_vec(7, 3, 27, 1'b1, 1, 2, 1);
    put(5, 0, 8, 1); put(5, 1, 9, 2); put(5, 2, 10, 3);
    vecs[6] = make_vec(1000, 2, 15, 1'b0, 2, 2, 99);
    put(6, 0, 32'h8000_0000, 352); put(6, 1, 999, 999);
    vecs[7] = make_vec(11, 5, 36, 1'b0, 5, 5, 99);
    put(7, 0, 23, 1); put(7, 1, -1, 10); put(7, 2, 5, 5); put(7, 3, 7, 7); put(7, 4, 8, 8);

    for (int i = 0; i < (1<<AW); i++) src_mem[i] = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.p     = '0;
    bus.count = '0;
    repeat (2) @(negedge clk);
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset error", bus.error, 1'b0);
    check("reset rd_en", bus.rd_en, 1'b0);
    check("reset wr_en", bus.wr_en, 1'b0);
    check("reset mod_start", bus.mod_start, 1'b0);
    check("reset mod_m", bus.mod_m, 0);
    check("reset mod_p", bus.mod_p, 0);
    check("reset addrs", {bus.rd_addr, bus.wr_addr}, 0);
    check("reset wr_data", bus.wr_data, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV - 1; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start pulsed while busy must be ignored.
    src_mem[0] = 32'd20;
    hang_at    = 99;
    @(negedge clk);
    base_start = tot_start;
    b_wr       = wa_q.size();
    b_done     = tot_done;
    bus.start  = 1'b1; bus.p = 32'd7; bus.count = 9'd1;
    for (k = 1; k <= 50; k++) begin
      @(negedge clk);
      bus.start = (k == 3);
      if (k == 3) begin bus.p = '0; bus.count = '0; end
      if (bus.done) break;
    end
    check("busy_start done cycle", k, 8);
    check("busy_start error", bus.error, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_start done pulses", tot_done - b_done, 1);
    check("busy_start writes", wa_q.size() - b_wr, 1);
    if (wa_q.size() > b_wr) check("busy_start wr_data", wd_q[b_wr], 6);

    // Reset during WAIT_DONE of coefficient 2.
    for (int i = 0; i < 5; i++) src_mem[i] = vecs[7].coeff[i];
    @(negedge clk);
    base_start = tot_start;
    b_wr       = wa_q.size();
    bus.start  = 1'b1; bus.p = 32'd11; bus.count = 9'd5;
    n = 0;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.mod_start) n++;
      if (n == 3) break;
    end
    check("rst_mid third issue seen", n, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid busy", bus.busy, 1'b0);
    check("rst_mid outputs", {bus.rd_en, bus.wr_en, bus.mod_start, bus.done, bus.error}, 0);
    check("rst_mid mod_m/mod_p", {bus.mod_m, bus.mod_p}, 0);
    check("rst_mid wr_data", bus.wr_data, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid writes", wa_q.size() - b_wr, 2);
    if (wa_q.size() >= b_wr + 2) begin
      check("rst_mid wr0", {wa_q[b_wr], wd_q[b_wr]}, {8'd0, 32'd1});
      check("rst_mid wr1", {wa_q[b_wr+1], wd_q[b_wr+1]}, {8'd1, 32'd10});
    end
    run_vec(vecs[7], "rerun");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
